ppu_scanline_unit: RTL and testbench

Synchronous PPU fetch tracker for mapper cores. It replaces the per-mapper `ppu_rd`-clocked scanline detectors with one clocked block. It samples the PPU read strobe and address and counts scanlines and tiles. From a programmable zone table it drives a CHR bank, and it raises a scanline-compare IRQ. Mappers instantiate it beside the mapper logic, drive `cfg_*` from CPU register writes, and route `chr_bank` into `chr_addr`.

---
 rtl/ppu_scanline_unit.sv | 204 ++++++++++++++++++++
 tb/tb_ppu_scanline_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_scanline_unit.sv
// ppu_scanline_unit
//   Clocked PPU fetch tracker shared by mapper cores. Samples the PPU read
//   strobe and address, counts scanlines and tiles, drives a CHR bank from a
//   programmable zone table and (optionally) raises a scanline-compare IRQ.
//
// Optional feature macro: PPU_SCANLINE_IRQ_EN
//   defined   : irq_line / irq_en registers and the IRQ comparator are built.
//   undefined : irq is tied low, config indices 14/15 are ignored, irq_ack unused.
//
// Ports
//   clk, reset_n    : system clock, asynchronous active-low reset
//   ppu_rd          : PPU /RD, asynchronous to clk
//   ppu_addr[13:0]  : PPU address, stable before ppu_rd falls
//   vblank          : one-clock frame-restart pulse
//   cfg_we/addr/data: register writes (2k start, 2k+1 bank, 14 irq_line, 15 irq_en)
//   irq_ack         : clears irq
//   chr_bank        : current CHR bank
//   scanline        : current scanline count
//   in_frame        : high while rendering fetches are being seen
//   irq             : level IRQ, active high
module ppu_scanline_unit #(
  parameter int ZONES       = 4,
  parameter int BANK_W      = 2,
  parameter int NT_RUN      = 3,
  parameter int SWITCH_TILE = 40,
  parameter int IDLE_CYC    = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ppu_rd,
  input  logic [13:0]       ppu_addr,
  input  logic              vblank,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              irq_ack,
  output logic [BANK_W-1:0] chr_bank,
  output logic [7:0]        scanline,
  output logic              in_frame,
  output logic              irq
);

  typedef enum logic [0:0] {S_IDLE, S_RENDER} state_t;

  state_t            r_state;
  logic              r_rd_s1, r_rd_s2, r_rd_s3;
  logic              r_fv;          // fetch event delayed one clock, aligned with r_fa
  logic [1:0]        r_fa;          // only fa[13:12] are ever inspected
  logic [2:0]        r_run;
  logic [5:0]        r_tile;
  logic              r_a13_prev;
  logic [15:0]       r_idle;
  logic [7:0]        r_scanline;
  logic [BANK_W-1:0] r_chr_bank;
  logic              r_in_frame;
  logic [7:0]        r_start [ZONES];
  logic [BANK_W-1:0] r_bank  [ZONES];

  logic              w_fetch, w_process, w_restart, w_timeout;
  logic              w_nt, w_line_inc, w_tile_inc, w_switch;
  logic              w_zone_hit;
  logic [BANK_W-1:0] w_zone_bank;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // Idle level of /RD is high, so all three reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_s1 <= 1'b1;
      r_rd_s2 <= 1'b1;
      r_rd_s3 <= 1'b1;
      r_fv    <= 1'b0;
      r_fa    <= 2'b00;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples the pre-edge value of its neighbours.
      r_rd_s1 <= ppu_rd;
      r_rd_s2 <= r_rd_s1;
      r_rd_s3 <= r_rd_s2;
      r_fv    <= w_fetch;
      if (w_fetch) r_fa <= ppu_addr[13:12];
    end
  end

  assign w_fetch    = r_rd_s3 & ~r_rd_s2;
  assign w_process  = r_fv & ~vblank;               // vblank discards a coincident fetch
  assign w_timeout  = (r_idle == 16'(IDLE_CYC - 1));
  assign w_restart  = (r_state == S_RENDER) && (vblank || (!r_fv && w_timeout));
  assign w_nt       = (r_fa == 2'b10);
  assign w_line_inc = w_nt && (r_run == 3'(NT_RUN - 1));
  assign w_tile_inc = r_a13_prev & ~r_fa[1];
  assign w_switch   = ~r_a13_prev & r_fa[1] & (r_tile == 6'(SWITCH_TILE));

  // Zone lookup on the pre-update scanline; scanning downwards lets the
  // lowest matching zone overwrite higher ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_zone_hit  = 1'b0;
    w_zone_bank = '0;
    for (int k = ZONES - 1; k >= 0; k--) begin
      if (r_start[k] == r_scanline) begin
        w_zone_hit  = 1'b1;
        w_zone_bank = r_bank[k];
      end
    end
  end

  // Zone table. New values are visible to the lookup from the next clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the zone table is a handful of flops with defined power-up
      // contents, so it is reset like any other register (not a RAM).
      for (int k = 0; k < ZONES; k++) begin
        r_start[k] <= 8'(k * (256 / ZONES));
        r_bank[k]  <= BANK_W'(k);
      end
    end else if (cfg_we) begin
      // Indices at or above 2*ZONES (including 14/15) never match a zone.
      for (int k = 0; k < ZONES; k++) begin
        if (cfg_addr[3:1] == 3'(k)) begin
          if (cfg_addr[0]) r_bank[k]  <= cfg_data[BANK_W-1:0];
          else             r_start[k] <= cfg_data;
        end
      end
    end
  end

  // Frame FSM with counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_run      <= '0;
      r_tile     <= '0;
      r_a13_prev <= 1'b0;
      r_idle     <= '0;
      r_scanline <= '0;
      r_chr_bank <= '0;
      r_in_frame <= 1'b0;
    end else if (w_restart) begin
      r_state    <= S_IDLE;
      r_run      <= '0;
      r_tile     <= '0;
      r_a13_prev <= 1'b0;
      r_idle     <= '0;
      r_scanline <= '0;
      r_chr_bank <= r_bank[0];
      r_in_frame <= 1'b0;
    end else if (w_process) begin
      // Same processing in IDLE (counters already 0) and RENDER.
      r_state    <= S_RENDER;
      r_in_frame <= 1'b1;
      r_idle     <= '0;
      if (!w_nt)                         r_run <= '0;
      else if (r_run != 3'(NT_RUN))      r_run <= r_run + 3'd1;
      if (w_line_inc) begin
        r_scanline <= r_scanline + 8'd1;
        r_tile     <= '0;
      end else if (w_tile_inc && r_tile != 6'd63) begin
        r_tile     <= r_tile + 6'd1;
      end
      if (w_switch && w_zone_hit) r_chr_bank <= w_zone_bank;
      r_a13_prev <= r_fa[1];
    end else if (r_state == S_RENDER) begin
      r_idle <= r_idle + 16'd1;
    end
  end

  assign chr_bank = r_chr_bank;
  assign scanline = r_scanline;
  assign in_frame = r_in_frame;

`ifdef PPU_SCANLINE_IRQ_EN
  logic [7:0] r_irq_line;
  logic       r_irq_en;
  logic       r_irq;
  logic       w_irq_set, w_irq_clr;

  assign w_irq_set = w_process && w_line_inc && r_irq_en &&
                     (8'(r_scanline + 8'd1) == r_irq_line);
  assign w_irq_clr = irq_ack || (cfg_we && cfg_addr == 4'd15 && !cfg_data[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_line <= '0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr == 4'd14) r_irq_line <= cfg_data;
      if (cfg_we && cfg_addr == 4'd15) r_irq_en   <= cfg_data[0];
      if (w_irq_set)      r_irq <= 1'b1;   // set beats a coincident clear
      else if (w_irq_clr) r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
  logic w_unused;
  assign w_unused = ^ppu_addr[11:0];
`else
  assign irq = 1'b0;
  logic w_unused;
  assign w_unused = ^{ppu_addr[11:0], irq_ack};
`endif

endmodule

// File: tb/tb_ppu_scanline_unit.sv
// Directed self-checking bench for ppu_scanline_unit (default parameters).
// IRQ expectations follow whether PPU_SCANLINE_IRQ_EN is defined.
module tb_ppu_scanline_unit;

`ifdef PPU_SCANLINE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ppu_rd;
  logic [13:0] ppu_addr;
  logic        vblank;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        irq_ack;
  logic [1:0]  chr_bank;
  logic [7:0]  scanline;
  logic        in_frame;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  // Outputs sampled 4 clocks after the /RD falling edge.
  logic [1:0] s_bank;
  logic [7:0] s_line;
  logic       s_frame;
  logic       s_irq;

  ppu_scanline_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ppu_rd   (ppu_rd),
    .ppu_addr (ppu_addr),
    .vblank   (vblank),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .irq_ack  (irq_ack),
    .chr_bank (chr_bank),
    .scanline (scanline),
    .in_frame (in_frame),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One PPU read: /RD low for 4 clocks, high for 4. vb/ack are pulsed on the
  // clock where the fetch is processed (4th posedge after the falling edge).
  task automatic fetch_ex(input logic [13:0] addr, input logic vb, input logic ack);
    @(negedge clk);
    ppu_addr = addr;
    ppu_rd   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vblank  = vb;
    irq_ack = ack;
    @(posedge clk);
    #1;
    s_bank  = chr_bank;
    s_line  = scanline;
    s_frame = in_frame;
    s_irq   = irq;
    @(negedge clk);
    vblank  = 1'b0;
    irq_ack = 1'b0;
    ppu_rd  = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic fetch(input logic [13:0] addr);
    fetch_ex(addr, 1'b0, 1'b0);
  endtask

  // Three nametable fetches then a pattern fetch: exactly one scanline.
  task automatic line_group(input int n);
    for (int i = 0; i < n; i++) begin
      fetch(14'h2000);
      fetch(14'h2000);
      fetch(14'h2000);
      fetch(14'h0000);
    end
  endtask

  // a13 1->0 pairs: each pair bumps the tile counter once.
  task automatic tile_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      fetch(14'h2000);
      fetch(14'h0000);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    ppu_rd   = 1'b1;
    ppu_addr = 14'h0000;
    vblank   = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = 4'd0;
    cfg_data = 8'd0;
    irq_ack  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bank",  chr_bank, 0);
    check("rst_line",  scanline, 0);
    check("rst_frame", in_frame, 0);
    check("rst_irq",   irq,      0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_frame", in_frame, 0);

    // First fetches start the frame without counting
    for (int i = 0; i < 10; i++) fetch(14'h0000);
    check("start_frame", in_frame, 1);
    check("start_line",  scanline, 0);
    check("start_bank",  chr_bank, 0);

    // IRQ at line 10, then a set coinciding with an ack at line 11
    cfg_write(4'd14, 8'd10);
    cfg_write(4'd15, 8'd1);
    line_group(9);
    check("line9",      scanline, 9);
    check("irq_before", irq,      0);
    line_group(1);
    check("line10",   scanline, 10);
    check("irq_set",  irq,      IRQ_ON);
    cfg_write(4'd14, 8'd11);
    fetch(14'h2000);
    fetch(14'h2000);
    fetch_ex(14'h2000, 1'b0, 1'b1);
    check("line11_4clk",   s_line, 11);
    check("irq_set_wins",  s_irq,  IRQ_ON);
    fetch(14'h0000);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check("irq_acked", irq, 0);
    cfg_write(4'd15, 8'd0);

    // Count to 64; the 4th consecutive NT fetch must not increment
    line_group(52);
    check("line63", scanline, 63);
    fetch(14'h2000);
    fetch(14'h2000);
    fetch(14'h2000);
    check("line64", s_line, 64);
    fetch(14'h2000);
    check("nt4_no_inc", s_line, 64);
    fetch(14'h0000);

    // Zone switch: tile is 1 after the line, 39 pairs bring it to 40
    tile_pairs(39);
    check("bank_pre_switch", chr_bank, 0);
    fetch(14'h2000);
    check("bank_zone1_4clk", s_bank, 1);
    fetch(14'h0000);
    line_group(1);
    check("line65", scanline, 65);

    // Overlap: zones 1 and 2 both start at 65, zone 1 (bank 3) must win
    cfg_write(4'd2, 8'd65);
    cfg_write(4'd4, 8'd65);
    cfg_write(4'd3, 8'd3);
    tile_pairs(39);
    check("bank_hold", chr_bank, 1);
    fetch(14'h2000);
    check("bank_overlap", s_bank, 3);

    // Idle timeout restores bank[0]
    cfg_write(4'd1, 8'd2);
    repeat (2000) @(posedge clk);
    #1;
    check("timeout_not_yet", in_frame, 1);
    repeat (100) @(posedge clk);
    #1;
    check("timeout_frame", in_frame, 0);
    check("timeout_line",  scanline, 0);
    check("timeout_bank",  chr_bank, 2);
    check("timeout_irq",   irq,      0);

    // vblank coincident with a fetch discards it
    fetch_ex(14'h0000, 1'b1, 1'b0);
    check("vb_fetch_ignored", s_frame, 0);
    fetch(14'h0000);
    check("restart_frame", in_frame, 1);
    line_group(1);
    check("restart_line1", scanline, 1);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    check("vb_frame", in_frame, 0);
    check("vb_line",  scanline, 0);

    // Reset mid-frame at scanline 100
    fetch(14'h0000);
    line_group(100);
    check("line100",      scanline, 100);
    check("bank_mid",     chr_bank, 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_bank",  chr_bank, 0);
    check("mid_rst_line",  scanline, 0);
    check("mid_rst_frame", in_frame, 0);
    check("mid_rst_irq",   irq,      0);
    @(negedge clk);
    reset_n = 1'b1;
    fetch(14'h0000);
    check("post_rst_frame", in_frame, 1);
    check("post_rst_line",  scanline, 0);
    line_group(1);
    check("post_rst_line1", scanline, 1);
    check("post_rst_bank",  chr_bank, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
